seg_digit_scan: RTL and testbench

Time-multiplexed four-digit scan driver for the common-anode seven-segment displays on the NEStoVGA board. It latches a 16-bit hex value, presents one nibble per slot to the downstream hex-to-segment decoder, and drives active-low digit enables and decimal point. Double buffering makes new values take effect only at frame boundaries, so digits never tear. Optional leading-zero blanking applies.

---
 rtl/seg_scan_pkg.sv | 31 +++
 rtl/scan_prescaler.sv | 34 +++
 rtl/seg_digit_scan.sv | 117 +++++++++++
 tb/tb_seg_digit_scan.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the four-digit seven-segment scan driver.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    // One displayable frame: four hex nibbles plus their decimal points.
    // hex[0] is the rightmost digit.
    typedef struct packed {
        nibble_t [NUM_DIGITS-1:0] hex;
        logic    [NUM_DIGITS-1:0] dp;
    } disp_word_t;

    // A digit is a leading zero when it is not digit 0 and it and every
    // digit to its left hold zero.
    function automatic logic lz_blanked(input nibble_t [NUM_DIGITS-1:0] hex,
                                        input digit_idx_t              idx,
                                        input logic                    enable);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && hex[k[1:0]] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        return enable && (idx != 2'd0) && upper_zero;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..TICK_DIV-1 and flags the last cycle.
module scan_prescaler #(
    parameter int  TICK_DIV = 50_000,
    localparam int CW       = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap to zero on the last cycle of the slot, otherwise increment.
    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seg_digit_scan.sv
// Four-digit multiplexed seven-segment scan driver with frame-aligned
// double buffering, leading-zero blanking and anti-ghosting dead time.
//
// Handshake: load is a single-cycle strobe with no back-pressure; the value
// is always accepted into the pending buffer and becomes visible at the next
// frame boundary (digit 3 -> digit 0), signalled by a one-cycle updated pulse.
module seg_digit_scan
    import seg_scan_pkg::*;
#(
    parameter int TICK_DIV = 50_000,
    parameter int DEAD     = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  nibble,
    output logic [3:0]  digit_en_n,
    output logic        dp_n,
    output logic        updated
);

    localparam int            CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic [CW-1:0] count;
    logic          tick;
    logic [CW-1:0] count_next;
    logic          frame_boundary;
    logic          show;

    digit_idx_t idx_q,        idx_d;
    disp_word_t active_q,     active_d;
    disp_word_t pending_q,    pending_d;
    logic       pend_flag_q,  pend_flag_d;
    nibble_t    nibble_q,     nibble_d;
    logic [3:0] digit_en_n_q, digit_en_n_d;
    logic       dp_n_q,       dp_n_d;
    logic       updated_q,    updated_d;

    scan_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .count  (count),
        .tick   (tick)
    );

    // Next digit, buffer promotion and the registered output values. Outputs
    // are computed from next-cycle state so they line up with count/idx.
    always_comb begin
        count_next     = tick ? '0 : count + 1'b1;
        idx_d          = tick ? idx_q + 2'd1 : idx_q;
        frame_boundary = tick && (idx_q == 2'd3);

        active_d    = active_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        updated_d   = 1'b0;

        // Promotion uses the pre-load pending contents; a load in the same
        // cycle then refills pending and keeps the flag set.
        if (frame_boundary && pend_flag_q) begin
            active_d    = pending_q;
            pend_flag_d = 1'b0;
            updated_d   = 1'b1;
        end
        if (load) begin
            pending_d.hex = value;
            pending_d.dp  = dp_in;
            pend_flag_d   = 1'b1;
        end

        show = (count_next >= DEAD_C) && !blank
               && !lz_blanked(active_d.hex, idx_d, BLANK_LZ);

        digit_en_n_d = 4'hF;
        if (show) begin
            digit_en_n_d[idx_d] = 1'b0;
        end
        dp_n_d   = !(show && active_d.dp[idx_d]);
        nibble_d = active_d.hex[idx_d];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= 2'd0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_n_q <= 4'hF;
            dp_n_q       <= 1'b1;
            updated_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            nibble_q     <= nibble_d;
            digit_en_n_q <= digit_en_n_d;
            dp_n_q       <= dp_n_d;
            updated_q    <= updated_d;
        end
    end

    assign nibble     = nibble_q;
    assign digit_en_n = digit_en_n_q;
    assign dp_n       = dp_n_q;
    assign updated    = updated_q;

endmodule

// File: tb/tb_seg_digit_scan.sv
// Bench for seg_digit_scan: two instances (leading-zero blanking on and off)
// share stimulus and are compared each cycle against a frame-arithmetic model.
module tb_seg_digit_scan;

    localparam int TDIV  = 8;
    localparam int DEADC = 2;
    localparam int FRAME = 4 * TDIV;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        load  = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank = 1'b0;

    logic [3:0] nib_lz, en_lz, nib_nz, en_nz;
    logic       dpn_lz, upd_lz, dpn_nz, upd_nz;

    seg_digit_scan #(.TICK_DIV(TDIV), .DEAD(DEADC), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
        .blank(blank), .nibble(nib_lz), .digit_en_n(en_lz), .dp_n(dpn_lz),
        .updated(upd_lz)
    );

    seg_digit_scan #(.TICK_DIV(TDIV), .DEAD(DEADC), .BLANK_LZ(1'b0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
        .blank(blank), .nibble(nib_nz), .digit_en_n(en_nz), .dp_n(dpn_nz),
        .updated(upd_nz)
    );

    // ---------------- scoreboard counters ----------------
    int vectors     = 0;
    int miscompares = 0;
    int upd_count   = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (time %0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t = clock edges since reset release; slot position and digit follow
    // directly from t, and frames start where t is a multiple of FRAME.
    int unsigned t         = 0;
    logic [15:0] m_pend_v  = 16'h0;
    logic [3:0]  m_pend_dp = 4'h0;
    logic [15:0] m_act_v   = 16'h0;
    logic [3:0]  m_act_dp  = 4'h0;
    bit          m_pflag   = 1'b0;
    logic [3:0]  e_nib     = 4'h0;
    logic [3:0]  e_en_lz   = 4'hF;
    logic [3:0]  e_en_nz   = 4'hF;
    logic        e_dp_lz   = 1'b1;
    logic        e_dp_nz   = 1'b1;
    logic        e_upd     = 1'b0;

    function automatic bit lead_zero(input logic [15:0] v, input int d);
        return (d != 0) && ((v >> (4 * d)) == 16'h0);
    endfunction

    always begin
        int d;
        int pos;
        bit on;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            t = 0; m_pend_v = 0; m_pend_dp = 0; m_act_v = 0; m_act_dp = 0;
            m_pflag = 0; e_nib = 0; e_en_lz = 4'hF; e_en_nz = 4'hF;
            e_dp_lz = 1; e_dp_nz = 1; e_upd = 0;
        end else begin
            t     = t + 1;
            e_upd = 1'b0;
            if ((t % FRAME) == 0 && m_pflag) begin
                m_act_v  = m_pend_v;
                m_act_dp = m_pend_dp;
                m_pflag  = 1'b0;
                e_upd    = 1'b1;
            end
            if (load) begin
                m_pend_v  = value;
                m_pend_dp = dp_in;
                m_pflag   = 1'b1;
            end
            d     = int'((t / TDIV) % 4);
            pos   = int'(t % TDIV);
            e_nib = m_act_v[4*d +: 4];
            on    = (pos >= DEADC) && !blank;
            e_en_lz = 4'hF;
            e_en_nz = 4'hF;
            if (on && !lead_zero(m_act_v, d)) e_en_lz[d] = 1'b0;
            if (on) e_en_nz[d] = 1'b0;
            e_dp_lz = !(on && !lead_zero(m_act_v, d) && m_act_dp[d]);
            e_dp_nz = !(on && m_act_dp[d]);
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        check("nibble_lz", nib_lz, e_nib);
        check("en_lz", en_lz, e_en_lz);
        check("dp_n_lz", {3'b000, dpn_lz}, {3'b000, e_dp_lz});
        check("updated_lz", {3'b000, upd_lz}, {3'b000, e_upd});
        check("nibble_nz", nib_nz, e_nib);
        check("en_nz", en_nz, e_en_nz);
        check("dp_n_nz", {3'b000, dpn_nz}, {3'b000, e_dp_nz});
        check("updated_nz", {3'b000, upd_nz}, {3'b000, e_upd});
        if (upd_lz) upd_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int ph);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8 && !hit; i++) begin
            @(negedge clk);
            if ((t % FRAME) == ph) hit = 1'b1;
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: phase %0d not reached", ph);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        load  = 1'b1;
        value = v;
        dp_in = dp;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic lit_slot(input string name, input logic [3:0] nib,
                            input logic [3:0] en, input logic dpn);
        check({name, "_nib"}, nib_lz, nib);
        check({name, "_en"}, en_lz, en);
        check({name, "_dp"}, {3'b000, dpn_lz}, {3'b000, dpn});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int r;

        // Reset state
        repeat (3) @(negedge clk);
        lit_slot("reset", 4'h0, 4'hF, 1'b1);
        check("reset_upd", {3'b000, upd_lz}, 4'h0);
        reset_n = 1'b1;

        // Idle scan: only digit 0 enabled, from slot cycle DEAD onward
        wait_phase(1);
        lit_slot("idle_c1", 4'h0, 4'hF, 1'b1);
        wait_phase(2);
        lit_slot("idle_c2", 4'h0, 4'b1110, 1'b1);
        wait_phase(7);
        lit_slot("idle_c7", 4'h0, 4'b1110, 1'b1);
        wait_phase(12);
        lit_slot("idle_d1", 4'h0, 4'hF, 1'b1);
        wait_phase(0);
        check("idle_no_update", upd_count[3:0], 4'h0);

        // 1234 with dp on digit 0
        do_load(16'h1234, 4'b0001);
        wait_phase(0);
        check("load1234_upd", {3'b000, upd_lz}, 4'h1);
        wait_phase(4);  lit_slot("h1234_d0", 4'h4, 4'b1110, 1'b0);
        wait_phase(12); lit_slot("h1234_d1", 4'h3, 4'b1101, 1'b1);
        wait_phase(20); lit_slot("h1234_d2", 4'h2, 4'b1011, 1'b1);
        wait_phase(28); lit_slot("h1234_d3", 4'h1, 4'b0111, 1'b1);

        // Leading-zero blanking, 00A0
        do_load(16'h00A0, 4'b0000);
        wait_phase(4);  lit_slot("h00a0_d0", 4'h0, 4'b1110, 1'b1);
        check("h00a0_nz_d0", en_nz, 4'b1110);
        wait_phase(12); lit_slot("h00a0_d1", 4'hA, 4'b1101, 1'b1);
        wait_phase(20); lit_slot("h00a0_d2", 4'h0, 4'hF, 1'b1);
        check("h00a0_nz_d2", en_nz, 4'b1011);
        wait_phase(28); lit_slot("h00a0_d3", 4'h0, 4'hF, 1'b1);
        check("h00a0_nz_d3", en_nz, 4'b0111);

        // Two loads in one frame: last wins, one pulse
        wait_phase(1);
        base = upd_count;
        do_load(16'h1111, 4'h0);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'h0);
        wait_phase(4);
        lit_slot("h2222_d0", 4'h2, 4'b1110, 1'b1);
        wait_phase(1);
        check("double_load_pulses", 4'(upd_count - base), 4'h1);

        // Load coinciding with a boundary while pending is full
        wait_phase(10);
        base = upd_count;
        do_load(16'hAAAA, 4'h0);
        wait_phase(31);
        do_load(16'hBBBB, 4'h0);
        check("coinc_nib", nib_lz, 4'hA);
        check("coinc_upd", {3'b000, upd_lz}, 4'h1);
        wait_phase(4);
        check("coinc_first", nib_lz, 4'hA);
        wait_phase(4);
        check("coinc_second", nib_lz, 4'hB);
        wait_phase(5);
        check("coinc_pulses", 4'(upd_count - base), 4'h2);

        // Randomized loads, values with varying leading zeros, blank toggles
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r     = int'($urandom_range(0, 4));
            load  = ($urandom_range(0, 9) == 0);
            value = 16'($urandom) >> (4 * r);
            dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank = ~blank;
        end
        @(negedge clk);
        load  = 1'b0;
        blank = 1'b0;

        // Blank takes effect one cycle after being sampled
        do_load(16'h5678, 4'hF);
        wait_phase(0);
        wait_phase(3);
        blank = 1'b1;
        @(negedge clk);
        lit_slot("blank_on", 4'h8, 4'hF, 1'b1);
        blank = 1'b0;
        @(negedge clk);
        lit_slot("blank_off", 4'h8, 4'b1110, 1'b0);

        // Asynchronous reset mid-slot
        wait_phase(13);
        lit_slot("pre_reset", 4'h7, 4'b1101, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        lit_slot("async_reset", 4'h0, 4'hF, 1'b1);
        check("async_reset_nz_en", en_nz, 4'hF);
        check("async_reset_nz_nib", nib_nz, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_phase(2);
        lit_slot("after_reset", 4'h0, 4'b1110, 1'b1);
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
